// File: rtl/hs_reg_slice.sv
// hs_reg_slice: valid/ready register slice with selectable register mode.
//
// Cuts timing paths between a stream source and destination on a single clock.
// MODE selects the register structure:
//   0 = bypass  : pure wires, no state
//   1 = forward : dst_valid/dst_data registered, src_ready combinational
//   2 = backward: src_ready registered, one-entry skid buffer
//   3 = full    : two-entry buffer, src_ready and dst_valid both registered
//
// Ports:
//   clk        rising-edge clock
//   s_rst      synchronous active-high reset
//   flush      synchronous discard of all stored entries (MODE 1-3)
//   src_valid  source offers src_data
//   src_data   source payload [WIDTH]
//   src_ready  slice accepts this cycle
//   dst_valid  slice offers dst_data
//   dst_data   output payload [WIDTH]
//   dst_ready  destination accepts
//   occupancy  stored entries, 0..2
//   xfer_cnt   destination handshake count, wraps modulo 2^CNT_W

module hs_reg_slice #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MODE  = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             s_rst,
   input  logic             flush,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   output logic             src_ready,
   output logic             dst_valid,
   output logic [WIDTH-1:0] dst_data,
   input  logic             dst_ready,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] xfer_cnt
);

   // ---------------------------------------------------------------------------
   // Transfer counter, common to every mode
   // ---------------------------------------------------------------------------
   logic             dst_xfer;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   assign dst_xfer = dst_valid & dst_ready;

   always_comb begin
      cnt_d = cnt_q;
      if (dst_xfer) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign xfer_cnt = cnt_q;

   // ---------------------------------------------------------------------------
   // Mode-specific datapath
   // ---------------------------------------------------------------------------
   if (MODE == 0) begin : g_bypass

      // Bypass has nothing to discard.
      logic unused_flush;
      assign unused_flush = flush;

      assign dst_valid = src_valid;
      assign dst_data  = src_data;
      assign src_ready = dst_ready;
      assign occupancy = 2'd0;

   end else if (MODE == 1) begin : g_fwd

      logic             vld_d;
      logic             vld_q;
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;
      logic             load;

      always_comb begin
         // Ready whenever the output register is empty or being drained.
         src_ready = ~s_rst & (~vld_q | dst_ready);
         load      = src_valid & src_ready;
         vld_d     = vld_q;
         data_d    = data_q;
         if (flush) begin
            vld_d = 1'b0;
         end else if (load) begin
            vld_d  = 1'b1;
            data_d = src_data;
         end else if (dst_ready) begin
            vld_d = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (s_rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
         end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
         end
      end

      assign dst_valid = vld_q;
      assign dst_data  = data_q;
      assign occupancy = {1'b0, vld_q};

   end else if (MODE == 2) begin : g_skid

      logic             full_d;
      logic             full_q;
      logic             rdy_d;
      logic             rdy_q;
      logic [WIDTH-1:0] skid_d;
      logic [WIDTH-1:0] skid_q;

      always_comb begin
         // rdy_q mirrors !full_q; the reset gate keeps the port low during reset.
         src_ready = rdy_q & ~s_rst;
         dst_valid = full_q | (src_valid & src_ready);
         dst_data  = full_q ? skid_q : src_data;
         full_d    = full_q;
         skid_d    = skid_q;
         if (flush) begin
            full_d = 1'b0;
         end else if (full_q) begin
            if (dst_ready) begin
               full_d = 1'b0;
            end
         end else if (src_valid & src_ready & ~dst_ready) begin
            // Beat accepted but not taken downstream: park it in the skid.
            full_d = 1'b1;
            skid_d = src_data;
         end
         rdy_d = ~full_d;
      end

      always_ff @(posedge clk) begin
         if (s_rst) begin
            full_q <= 1'b0;
            rdy_q  <= 1'b1;
            skid_q <= '0;
         end else begin
            full_q <= full_d;
            rdy_q  <= rdy_d;
            skid_q <= skid_d;
         end
      end

      assign occupancy = {1'b0, full_q};

   end else begin : g_full

      logic [WIDTH-1:0] mem_d [2];
      logic [WIDTH-1:0] mem_q [2];
      logic             wr_ptr_d;
      logic             wr_ptr_q;
      logic             rd_ptr_d;
      logic             rd_ptr_q;
      logic [1:0]       fill_d;
      logic [1:0]       fill_q;
      logic             rdy_d;
      logic             rdy_q;
      logic             vld_d;
      logic             vld_q;
      logic             push;
      logic             pop;

      always_comb begin
         src_ready = rdy_q & ~s_rst;
         push      = src_valid & src_ready;
         pop       = vld_q & dst_ready;
         mem_d     = mem_q;
         wr_ptr_d  = wr_ptr_q;
         rd_ptr_d  = rd_ptr_q;
         fill_d    = fill_q;
         if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            fill_d   = 2'd0;
         end else begin
            if (push) begin
               mem_d[wr_ptr_q] = src_data;
               wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_d = ~rd_ptr_q;
            end
            // Simultaneous push and pop leave the fill level unchanged.
            case ({push, pop})
               2'b10:   fill_d = fill_q + 2'd1;
               2'b01:   fill_d = fill_q - 2'd1;
               default: fill_d = fill_q;
            endcase
         end
         // Both handshake flags are registered from the next fill level.
         rdy_d = (fill_d != 2'd2);
         vld_d = (fill_d != 2'd0);
      end

      always_ff @(posedge clk) begin
         if (s_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
         end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
         end
      end

      assign dst_valid = vld_q;
      assign dst_data  = mem_q[rd_ptr_q];
      assign occupancy = fill_q;

   end

endmodule

// File: tb/tb_hs_reg_slice.sv
// Testbench for hs_reg_slice: one instance per MODE (0..3, CNT_W=16) plus a
// MODE 3 instance with CNT_W=4 for counter wrap. A negedge monitor keeps a
// queue per instance of accepted-but-undelivered beats and checks every output
// against it.

module tb_hs_reg_slice;

   localparam int NI = 5;

   typedef logic [7:0] byte_q_t [$];

   logic        clk = 1'b0;
   logic        s_rst;
   logic        flush     [NI];
   logic        src_valid [NI];
   logic [7:0]  src_data  [NI];
   logic        src_ready [NI];
   logic        dst_valid [NI];
   logic [7:0]  dst_data  [NI];
   logic        dst_ready [NI];
   logic [1:0]  occupancy [NI];
   logic [15:0] xcnt      [NI];
   logic [3:0]  xcnt_w;

   int n_tests = 0;
   int n_fail  = 0;

   byte_q_t     exp_q   [NI];
   int unsigned exp_cnt [NI];
   bit          rst_seen = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      hs_reg_slice #(.WIDTH(8), .MODE(g), .CNT_W(16)) u_dut (
         .clk       (clk),
         .s_rst     (s_rst),
         .flush     (flush[g]),
         .src_valid (src_valid[g]),
         .src_data  (src_data[g]),
         .src_ready (src_ready[g]),
         .dst_valid (dst_valid[g]),
         .dst_data  (dst_data[g]),
         .dst_ready (dst_ready[g]),
         .occupancy (occupancy[g]),
         .xfer_cnt  (xcnt[g])
      );
   end

   hs_reg_slice #(.WIDTH(8), .MODE(3), .CNT_W(4)) u_wrap (
      .clk       (clk),
      .s_rst     (s_rst),
      .flush     (flush[4]),
      .src_valid (src_valid[4]),
      .src_data  (src_data[4]),
      .src_ready (src_ready[4]),
      .dst_valid (dst_valid[4]),
      .dst_data  (dst_data[4]),
      .dst_ready (dst_ready[4]),
      .occupancy (occupancy[4]),
      .xfer_cnt  (xcnt_w)
   );

   assign xcnt[4] = {12'd0, xcnt_w};

   function automatic int mode_of(input int i);
      return (i == 4) ? 3 : i;
   endfunction

   function automatic void chk(input string name, input int inst, input logic [31:0] act,
                               input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d t=%0t got=%0h expected=%0h", name, inst, $time, act, exp);
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard. Reference behaviour: every accepted beat (not in a
   // flush cycle) joins the back of a queue; every destination handshake must
   // present the front. Registered modes hold exactly the queue contents.
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int          md;
         int          sz;
         logic        sx;
         logic        dx;
         logic [15:0] mask;
         md   = mode_of(i);
         sz   = exp_q[i].size();
         mask = (i == 4) ? 16'h000F : 16'hFFFF;
         if (s_rst) begin
            if (md != 0) chk("rst_src_ready", i, 32'(src_ready[i]), 32'd0);
            if (rst_seen) begin
               chk("rst_occupancy", i, 32'(occupancy[i]), 32'd0);
               chk("rst_xfer_cnt", i, 32'(xcnt[i]), 32'd0);
               if (md != 0) chk("rst_dst_valid", i, 32'(dst_valid[i]), 32'd0);
            end
            exp_q[i].delete();
            exp_cnt[i] = 0;
         end else begin
            sx = src_valid[i] & src_ready[i];
            dx = dst_valid[i] & dst_ready[i];
            chk("xfer_cnt", i, 32'(xcnt[i]), 32'(exp_cnt[i][15:0] & mask));
            case (md)
               0: begin
                  chk("occupancy", i, 32'(occupancy[i]), 32'd0);
                  chk("bypass_valid", i, 32'(dst_valid[i]), 32'(src_valid[i]));
                  chk("bypass_ready", i, 32'(src_ready[i]), 32'(dst_ready[i]));
                  if (src_valid[i]) chk("bypass_data", i, 32'(dst_data[i]), 32'(src_data[i]));
               end
               1: begin
                  chk("occupancy", i, 32'(occupancy[i]), 32'(sz));
                  chk("dst_valid", i, 32'(dst_valid[i]), 32'(sz != 0));
                  chk("src_ready", i, 32'(src_ready[i]), 32'((sz == 0) || dst_ready[i]));
               end
               2: begin
                  chk("occupancy", i, 32'(occupancy[i]), 32'(sz));
                  chk("src_ready", i, 32'(src_ready[i]), 32'(sz == 0));
                  chk("dst_valid", i, 32'(dst_valid[i]), 32'((sz != 0) || src_valid[i]));
               end
               default: begin
                  chk("occupancy", i, 32'(occupancy[i]), 32'(sz));
                  chk("dst_valid", i, 32'(dst_valid[i]), 32'(sz != 0));
                  chk("src_ready", i, 32'(src_ready[i]), 32'(sz < 2));
               end
            endcase
            if (md != 0) begin
               if (sx && !flush[i]) exp_q[i].push_back(src_data[i]);
               if (dst_valid[i]) begin
                  if (exp_q[i].size() == 0) begin
                     chk("dst_valid_no_data", i, 32'(dst_valid[i]), 32'd0);
                  end else begin
                     chk("dst_data", i, 32'(dst_data[i]), 32'(exp_q[i][0]));
                     if (dx) void'(exp_q[i].pop_front());
                  end
               end
               if (flush[i]) exp_q[i].delete();
            end
            if (dx) exp_cnt[i]++;
         end
      end
      rst_seen = s_rst;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int i = 0; i < NI; i++) begin
         flush[i]     = 1'b0;
         src_valid[i] = 1'b0;
         src_data[i]  = 8'h00;
         dst_ready[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      s_rst = 1'b1;
      idle_all();
      repeat (2) step();
      s_rst = 1'b0;
   endtask

   // Sends n beats to instance i. seq: data base, base+1, ...; else random.
   // use_pat drives dst_ready with the repeating 1,0,0,1 pattern.
   task automatic run_stream(input int i, input int n, input int vpct, input int rpct,
                             input bit seq, input logic [7:0] base, input bit use_pat,
                             output int stalls, output int max_occ);
      bit         pat [4];
      int         sent;
      int         cyc;
      logic [7:0] d;
      pat     = '{1'b1, 1'b0, 1'b0, 1'b1};
      sent    = 0;
      cyc     = 0;
      stalls  = 0;
      max_occ = 0;
      d       = seq ? base : 8'($urandom);
      while (sent < n && cyc < 20 * n + 100) begin
         src_valid[i] = ($urandom_range(99) < vpct);
         src_data[i]  = src_valid[i] ? d : 8'($urandom);
         dst_ready[i] = use_pat ? pat[cyc % 4] : ($urandom_range(99) < rpct);
         @(negedge clk);
         if (src_valid[i] && !src_ready[i]) stalls++;
         if (int'(occupancy[i]) > max_occ) max_occ = int'(occupancy[i]);
         if (src_valid[i] && src_ready[i]) begin
            sent++;
            d = seq ? base + 8'(sent) : 8'($urandom);
         end
         step();
         cyc++;
      end
      chk("stream_beats_sent", i, 32'(sent), 32'(n));
      src_valid[i] = 1'b0;
   endtask

   task automatic drain(input int i);
      int c;
      c            = 0;
      src_valid[i] = 1'b0;
      dst_ready[i] = 1'b1;
      while (occupancy[i] != 2'd0 && c < 20) begin
         step();
         c++;
      end
      step();
      chk("drain_empty", i, 32'(occupancy[i]), 32'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed and random scenarios
   // ---------------------------------------------------------------------------
   initial begin
      int         stalls;
      int         max_occ;
      int         acc;
      logic [7:0] d;
      s_rst = 1'b1;
      idle_all();
      #1;

      // MODE 3 back-to-back 0x01..0x10 with dst always ready.
      do_reset();
      run_stream(3, 16, 100, 100, 1'b1, 8'h01, 1'b0, stalls, max_occ);
      chk("m3_no_stall", 3, 32'(stalls), 32'd0);
      drain(3);
      chk("m3_xfer16", 3, 32'(xcnt[3]), 32'd16);

      // MODE 3 backpressure: A1, A2 fill the buffer, A3 is held.
      do_reset();
      acc = 0;
      d   = 8'hA1;
      dst_ready[3] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         src_valid[3] = 1'b1;
         src_data[3]  = d;
         @(negedge clk);
         if (src_ready[3]) begin
            acc++;
            d = d + 8'd1;
         end
         step();
      end
      @(negedge clk);
      chk("bp_accepted", 3, 32'(acc), 32'd2);
      chk("bp_occupancy", 3, 32'(occupancy[3]), 32'd2);
      chk("bp_src_ready", 3, 32'(src_ready[3]), 32'd0);
      step();
      dst_ready[3] = 1'b1;
      for (int k = 0; k < 10 && acc < 3; k++) begin
         @(negedge clk);
         if (src_ready[3]) acc++;
         step();
      end
      chk("bp_third_accepted", 3, 32'(acc), 32'd3);
      drain(3);
      chk("bp_xfer3", 3, 32'(xcnt[3]), 32'd3);

      // MODE 2 skid with dst_ready 1,0,0,1 while streaming 0x10..0x1F.
      do_reset();
      run_stream(2, 16, 100, 0, 1'b1, 8'h10, 1'b1, stalls, max_occ);
      chk("m2_skid_used", 2, 32'(max_occ), 32'd1);
      drain(2);
      chk("m2_xfer16", 2, 32'(xcnt[2]), 32'd16);

      // MODE 1 and MODE 0 random valid/ready, 1000 beats each.
      do_reset();
      run_stream(1, 1000, 70, 70, 1'b0, 8'h00, 1'b0, stalls, max_occ);
      drain(1);
      chk("m1_xfer1000", 1, 32'(xcnt[1]), 32'd1000);
      do_reset();
      run_stream(0, 1000, 70, 70, 1'b0, 8'h00, 1'b0, stalls, max_occ);
      drain(0);
      chk("m0_xfer1000", 0, 32'(xcnt[0]), 32'd1000);

      // MODE 3 flush with a full buffer and 0x55 offered.
      do_reset();
      run_stream(3, 2, 100, 0, 1'b1, 8'h11, 1'b0, stalls, max_occ);
      @(negedge clk);
      chk("fl_full", 3, 32'(occupancy[3]), 32'd2);
      step();
      flush[3]     = 1'b1;
      src_valid[3] = 1'b1;
      src_data[3]  = 8'h55;
      step();
      flush[3]     = 1'b0;
      src_valid[3] = 1'b0;
      @(negedge clk);
      chk("fl_occupancy", 3, 32'(occupancy[3]), 32'd0);
      chk("fl_dst_valid", 3, 32'(dst_valid[3]), 32'd0);
      chk("fl_src_ready", 3, 32'(src_ready[3]), 32'd1);
      step();
      dst_ready[3] = 1'b1;
      repeat (4) step();
      // Flush with one entry, an accepted 0x66 and a destination handshake.
      run_stream(3, 1, 100, 0, 1'b1, 8'h77, 1'b0, stalls, max_occ);
      flush[3]     = 1'b1;
      src_valid[3] = 1'b1;
      src_data[3]  = 8'h66;
      dst_ready[3] = 1'b1;
      step();
      flush[3]     = 1'b0;
      src_valid[3] = 1'b0;
      repeat (3) step();
      chk("fl_counted", 3, 32'(xcnt[3]), 32'd1);
      chk("fl2_occupancy", 3, 32'(occupancy[3]), 32'd0);

      // Reset mid-stream with occupancy 1 and xfer_cnt 5.
      do_reset();
      run_stream(3, 5, 100, 100, 1'b1, 8'h30, 1'b0, stalls, max_occ);
      drain(3);
      run_stream(3, 1, 100, 0, 1'b1, 8'h3F, 1'b0, stalls, max_occ);
      @(negedge clk);
      chk("mid_occupancy", 3, 32'(occupancy[3]), 32'd1);
      chk("mid_xfer5", 3, 32'(xcnt[3]), 32'd5);
      step();
      s_rst = 1'b1;
      step();
      @(negedge clk);
      chk("mid_rst_src_ready", 3, 32'(src_ready[3]), 32'd0);
      step();
      s_rst        = 1'b0;
      dst_ready[3] = 1'b0;
      @(negedge clk);
      chk("post_rst_occupancy", 3, 32'(occupancy[3]), 32'd0);
      chk("post_rst_dst_valid", 3, 32'(dst_valid[3]), 32'd0);
      chk("post_rst_xfer", 3, 32'(xcnt[3]), 32'd0);
      chk("post_rst_src_ready", 3, 32'(src_ready[3]), 32'd1);
      step();

      // CNT_W=4 wraps after 16 transfers.
      do_reset();
      run_stream(4, 17, 100, 100, 1'b1, 8'h40, 1'b0, stalls, max_occ);
      drain(4);
      chk("wrap_xfer", 4, 32'(xcnt_w), 32'd1);

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1, "watchdog");
   end

endmodule
